fpcvt_scheduler: RTL

Round-robin scheduler that shares one combinational floating-point converter (13-bit two's-complement in; sign, 3-bit exponent and 5-bit significand out) among NUM_REQ requesters. It accepts one sample at a time and holds the sample on the converter input for SETTLE_CYCLES cycles. It then captures the converter result and presents it, tagged with the requester ID, on a valid/ready output port. The block sits between the sample sources (switch/input logic) and the display/consumer logic.

---
 rtl/fpcvt_scheduler_if.sv | 39 +++
 rtl/fpcvt_scheduler.sv | 115 +++++++++++
 2 files changed

// File: rtl/fpcvt_scheduler_if.sv
// Bus bundle for fpcvt_scheduler.
//   req_valid/req_data/req_ready : NUM_REQ sample sources, 13-bit two's-complement
//                                  each, packed requester i at [13*i +: 13]
//   cvt_d -> cvt_s/cvt_e/cvt_f   : shared combinational converter (drive/return)
//   out_*                        : tagged result on a valid/ready port
//   busy                         : scheduler is not idle
// master = the scheduler; slave = sources, converter and consumer around it.
interface fpcvt_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [13*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;

  logic [12:0]           cvt_d;
  logic                  cvt_s;
  logic [2:0]            cvt_e;
  logic [4:0]            cvt_f;

  logic                  out_valid;
  logic                  out_ready;
  logic [ID_W-1:0]       out_id;
  logic                  out_s;
  logic [2:0]            out_e;
  logic [4:0]            out_f;

  logic                  busy;

  modport master (
    input  req_valid, req_data, cvt_s, cvt_e, cvt_f, out_ready,
    output req_ready, cvt_d, out_valid, out_id, out_s, out_e, out_f, busy
  );

  modport slave (
    output req_valid, req_data, cvt_s, cvt_e, cvt_f, out_ready,
    input  req_ready, cvt_d, out_valid, out_id, out_s, out_e, out_f, busy
  );
endinterface

// File: rtl/fpcvt_scheduler.sv
// Round-robin scheduler sharing one combinational float converter among
// NUM_REQ requesters. A granted sample is registered onto cvt_d, left to settle
// for SETTLE_CYCLES cycles, then the converter result is captured and offered
// on the out_* valid/ready port tagged with the requester ID.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active high
//   bus  - fpcvt_scheduler_if.master (requests, converter, result, busy)
module fpcvt_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                clk,
  input logic                rst,
  fpcvt_scheduler_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q;
  logic [ID_W-1:0]    last_q;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    grant_id;
  logic               grant_vld;
  logic [NUM_REQ-1:0] grant_oh;
  logic               load;
  logic               capture;

  // Round-robin search: candidates are last_q+1, last_q+2, ... modulo NUM_REQ.
  // Walking from the farthest candidate to the nearest lets the nearest set
  // bit overwrite the others, so no early exit is needed.
  always_comb begin : rr_search
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
    grant_oh           = '0;
    grant_oh[grant_id] = grant_vld;
  end

  always_comb begin : fsm_next
    state_d       = state_q;
    load          = 1'b0;
    capture       = 1'b0;
    bus.req_ready = '0;
    unique case (state_q)
      IDLE: begin
        // Gate with rst so no requester sees an acceptance that reset discards.
        if (grant_vld && !rst) begin
          load          = 1'b1;
          bus.req_ready = grant_oh;
          state_d       = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd1) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Release only; a new grant waits for the following IDLE cycle.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_q        <= ID_W'(NUM_REQ - 1);
      bus.cvt_d     <= '0;
      bus.out_id    <= '0;
      bus.out_s     <= 1'b0;
      bus.out_e     <= '0;
      bus.out_f     <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus.out_valid <= (state_d == HOLD);
      if (load) begin
        // cvt_d is only ever written here, so it holds the last granted sample.
        bus.cvt_d  <= bus.req_data[13*grant_id +: 13];
        bus.out_id <= grant_id;
        last_q     <= grant_id;
        cnt_q      <= 4'(SETTLE_CYCLES);
      end else if (state_q == SETTLE) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        bus.out_s <= bus.cvt_s;
        bus.out_e <= bus.cvt_e;
        bus.out_f <= bus.cvt_f;
      end
    end
  end

  assign bus.busy = (state_q != IDLE);

endmodule
